aes_tbox_lanes: RTL and testbench
=================================

# aes_tbox_lanes

Parametrised, pipelined AES T-table lookup engine serving `LANES` byte lanes per cycle. Each lane returns a 32-bit table word for its input byte, selected among encrypt T-tables Te0–Te3, decrypt T-tables Td0–Td3, or the final-round S-box/inverse-S-box word. The engine sits between the round-state register and the column-XOR network of the AES round datapath. It replaces the single fixed-Te0, single-lane, no-reset lookup with valid tracking, stall, and selectable latency.

## Interface
- `LANES`, default 4: number of independent byte lanes (1..16).
- `LATENCY`, default 1: pipeline depth, either 1 or 2 cycles.
- `clk` in, 1: clock, rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `en` in, 1: pipeline advance; when low, all stages hold.
- `in_valid` in, 1: input beat valid.
- `mode` in, 2: 0 = ENC, 1 = DEC, 2 = ENC_LAST, 3 = DEC_LAST; shared by all lanes.
- `in_byte` in, LANES*8: lane i byte at [8i+7:8i].
- `in_sel` in, LANES*2: lane i table index k (0..3) at [2i+1:2i].
- `out_valid` out, 1: output beat valid.
- `out` out, LANES*32: lane i word at [32i+31:32i].

## Operation
- S = AES S-box, Si = inverse S-box. GF(2^8) multiplication uses polynomial 0x11B.
- ENC, index k: Te0[x] = {2·S[x], S[x], S[x], 3·S[x]}, MSB first. Tek = Te0 rotated right by 8k bits.
- DEC, index k: Td0[x] = {0E·Si[x], 09·Si[x], 0D·Si[x], 0B·Si[x]}. Tdk = Td0 rotated right by 8k bits.
- ENC_LAST, index k: S[x] in byte position 3−k (byte 3 = bits 31:24); all other bytes zero.
- DEC_LAST, index k: Si[x] in byte position 3−k; all other bytes zero.
- Lanes are fully independent. `mode` applies to every lane of a beat.
- `mode`, `in_sel`, and `in_byte` are sampled together with `in_valid`, so a mode change takes effect on exactly the next accepted beat.
- Data is captured whether or not `in_valid` is high. `out` for an invalid beat is don't-care, but it must be deterministic.
- `out_valid` is the pipelined copy of `in_valid`. There is no backpressure output; the upstream block uses the same `en`.

## Timing
- Reset (asynchronous assert): `out_valid` = 0, `out` = 0, and every internal stage register = 0. Release is synchronous to `clk`.
- LATENCY = 1: at the edge with `en` = 1, the lookup result is registered into `out`. Result is visible one cycle after the input.
- LATENCY = 2:
  - Stage 1 registers `in_byte`, `in_sel`, `mode`, and `in_valid`.
  - Stage 2 registers the table word. Result is visible two cycles after the input.
- `en` = 0: no register updates, including valid bits; `out`/`out_valid` hold their values. A beat presented while `en` = 0 is not accepted.
- Throughput: one beat per `en` cycle, with no bubbles.
- Reset mid-stream: all in-flight beats are discarded; `out_valid` is 0 at the first edge after release.
- `rst` and `en` high together: reset wins.

## Structure
- Package `aes_tbox_pkg` holds:
  - `SBOX` and `INV_SBOX` 256×8 constant arrays.
  - `gmul` function (GF(2^8) multiply by constant).
  - `tbox_mode_t` enum: ENC, DEC, ENC_LAST, DEC_LAST.
  - `LANE_W` = 32 constant.
- Sub-module `aes_tbox_lane`: one combinational byte→word lookup with the byte, k, and mode inputs. It is instantiated `LANES` times in a generate loop.
- Top level owns all pipeline registers, the valid chain, and the `en` gating.
- `LATENCY` outside {1, 2} is an elaboration error.

## Test plan
- Reset sequence: LANES = 4, LATENCY = 1; assert `rst` mid-clock with valid data in flight. Required: `out` = 0 and `out_valid` = 0 immediately, with no clock edge needed.
- ENC, k = 0, bytes {00, 52, FF, 01}. Required: lanes = C66363A5, 00000000, 2C16163A, F87C7C84 one cycle later, with `out_valid` = 1.
- Rotation and DEC:
  - ENC, byte 01, k = 2. Required: 7C84F87C.
  - DEC, byte 00, k = 0. Required: 51F4A750.
  - DEC, byte 00, k = 1. Required: 5051F4A7.
- Last round:
  - ENC_LAST, byte 53, k = 0. Required: ED000000.
  - DEC_LAST, byte 00, k = 3. Required: 00000052.
- LATENCY = 2, back-to-back beats with `en` low for 3 cycles mid-stream. Required:
  - Outputs appear 2 enabled edges after their inputs, in order.
  - Outputs hold during the stall.
  - No beat is dropped or duplicated.
- Sweep all 256 bytes × 4 k × 4 modes against a reference model built from the package tables. Required: zero mismatches.

Source files
------------

// File: rtl/aes_tbox_pkg.sv
// AES T-table lookup engine: shared tables, GF(2^8) helper and mode encoding.
package aes_tbox_pkg;

    localparam int LANE_W = 32;

    typedef enum logic [1:0] {
        ENC      = 2'd0,
        DEC      = 2'd1,
        ENC_LAST = 2'd2,
        DEC_LAST = 2'd3
    } tbox_mode_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Shift-and-add multiply in GF(2^8), reduced by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_tbox_lane.sv
// One byte lane: combinational byte -> 32-bit T-table / last-round word.
module aes_tbox_lane
    import aes_tbox_pkg::*;
(
    input  logic [7:0]        byte_i,
    input  logic [1:0]        k_i,
    input  logic [1:0]        mode_i,
    output logic [LANE_W-1:0] word_o
);

    tbox_mode_t  mode_e;
    logic [7:0]  s;
    logic [7:0]  si;
    logic [31:0] t0;
    logic [31:0] rot;
    logic [31:0] last;

    // Build the k=0 table word, rotate right by whole bytes, or place the bare
    // S-box byte at byte position 3-k for the final round.
    always_comb begin
        mode_e = tbox_mode_t'(mode_i);
        s      = SBOX[byte_i];
        si     = INV_SBOX[byte_i];
        if (mode_e == DEC)
            t0 = {gmul(si, 8'h0E), gmul(si, 8'h09), gmul(si, 8'h0D), gmul(si, 8'h0B)};
        else
            t0 = {gmul(s, 8'h02), s, s, gmul(s, 8'h03)};
        case (k_i)
            2'd0:    rot = t0;
            2'd1:    rot = {t0[7:0],  t0[31:8]};
            2'd2:    rot = {t0[15:0], t0[31:16]};
            default: rot = {t0[23:0], t0[31:24]};
        endcase
        // 3-k on two bits is ~k; shift amount is that times 8
        last   = {24'd0, (mode_e == DEC_LAST) ? si : s} << {~k_i, 3'b000};
        word_o = (mode_e == ENC || mode_e == DEC) ? rot : last;
    end

endmodule

// File: rtl/aes_tbox_lanes.sv
// Multi-lane pipelined AES T-table lookup with valid chain, stall and 1/2-cycle latency.
module aes_tbox_lanes
    import aes_tbox_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic [1:0]              mode,
    input  logic [LANES*8-1:0]      in_byte,
    input  logic [LANES*2-1:0]      in_sel,
    output logic                    out_valid,
    output logic [LANES*LANE_W-1:0] out
);

    if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
        $error("aes_tbox_lanes: LATENCY must be 1 or 2");
    end

    // Valid chain: index 0 is the live input, index LATENCY is the output.
    logic [LATENCY-1:0] vld_pipe_q;
    logic [LATENCY-1:0] vld_pipe_d;
    logic [LATENCY:0]   vld_pipe;

    assign vld_pipe  = {vld_pipe_q, in_valid};
    assign out_valid = vld_pipe[LATENCY];

    // Shift valid bits only on enabled cycles.
    always_comb begin
        vld_pipe_d = vld_pipe_q;
        if (en) vld_pipe_d = vld_pipe[LATENCY-1:0];
    end

    // Valid chain register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe_q <= '0;
        else     vld_pipe_q <= vld_pipe_d;
    end

    // Lookup operands: either the raw inputs or a registered copy of them.
    logic [LANES*8-1:0] lk_byte;
    logic [LANES*2-1:0] lk_sel;
    logic [1:0]         lk_mode;

    if (LATENCY == 2) begin : g_stage1
        logic [LANES*8-1:0] byte_q, byte_d;
        logic [LANES*2-1:0] sel_q, sel_d;
        logic [1:0]         mode_q, mode_d;

        // Capture operands on every enabled cycle, valid or not.
        always_comb begin
            byte_d = byte_q;
            sel_d  = sel_q;
            mode_d = mode_q;
            if (en) begin
                byte_d = in_byte;
                sel_d  = in_sel;
                mode_d = mode;
            end
        end

        // Stage-1 operand register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                byte_q <= '0;
                sel_q  <= '0;
                mode_q <= '0;
            end else begin
                byte_q <= byte_d;
                sel_q  <= sel_d;
                mode_q <= mode_d;
            end
        end

        assign lk_byte = byte_q;
        assign lk_sel  = sel_q;
        assign lk_mode = mode_q;
    end else begin : g_direct
        assign lk_byte = in_byte;
        assign lk_sel  = in_sel;
        assign lk_mode = mode;
    end

    logic [LANES-1:0][LANE_W-1:0] lk_word;
    logic [LANES-1:0][LANE_W-1:0] out_q;
    logic [LANES-1:0][LANE_W-1:0] out_d;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        aes_tbox_lane u_lane (
            .byte_i (lk_byte[8*i +: 8]),
            .k_i    (lk_sel[2*i +: 2]),
            .mode_i (lk_mode),
            .word_o (lk_word[i])
        );
    end

    // Output register follows the lookup on enabled cycles, holds otherwise.
    always_comb begin
        out_d = out_q;
        if (en) out_d = lk_word;
    end

    // Output word register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_q <= '0;
        else     out_q <= out_d;
    end

    assign out = out_q;

endmodule

// File: tb/tb_aes_tbox_lanes.sv
// Bench for aes_tbox_lanes: LATENCY=1 and LATENCY=2 instances share one stimulus stream.
module tb_aes_tbox_lanes;

    localparam int L = 4;

    logic           clk = 1'b0;
    logic           rst, en, in_valid;
    logic [1:0]     mode;
    logic [L*8-1:0] in_byte;
    logic [L*2-1:0] in_sel;
    logic           ov1, ov2;
    logic [L*32-1:0] out1, out2;

    always #5 clk = ~clk;

    aes_tbox_lanes #(.LANES(L), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .mode(mode),
        .in_byte(in_byte), .in_sel(in_sel), .out_valid(ov1), .out(out1));

    aes_tbox_lanes #(.LANES(L), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .mode(mode),
        .in_byte(in_byte), .in_sel(in_sel), .out_valid(ov2), .out(out2));

    int checks = 0;
    int errors = 0;
    int acc2   = 0;
    int seen2  = 0;

    // Reference S-boxes derived from field inversion + affine map.
    logic [7:0] sb_m  [256];
    logic [7:0] isb_m [256];

    // Behavioural expectation of each pipeline.
    logic            m1_v, m2_s1v, m2_v;
    logic [L*32-1:0] m1_out, m2_out;
    logic [L*8-1:0]  m2_byte;
    logic [L*2-1:0]  m2_sel;
    logic [1:0]      m2_mode;

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011B << (i - 8));
        return prod[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    task automatic build_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sb_m[x]  = s;
            isb_m[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] ref_word(input int m, input int k, input logic [7:0] x);
        logic [7:0]  s, si;
        logic [31:0] w;
        s  = sb_m[x];
        si = isb_m[x];
        case (m)
            0: w = {gm(s, 8'h02), s, s, gm(s, 8'h03)};
            1: w = {gm(si, 8'h0E), gm(si, 8'h09), gm(si, 8'h0D), gm(si, 8'h0B)};
            2: return 32'(s)  << (8 * (3 - k));
            default: return 32'(si) << (8 * (3 - k));
        endcase
        if (k == 0) return w;
        return (w >> (8 * k)) | (w << (32 - 8 * k));
    endfunction

    function automatic logic [L*32-1:0] ref_beat(input logic [1:0] m, input logic [L*2-1:0] sel,
                                               input logic [L*8-1:0] bytes);
        logic [L*32-1:0] r;
        r = '0;
        for (int i = 0; i < L; i++)
            r[32*i +: 32] = ref_word(int'(m), int'(sel[2*i +: 2]), bytes[8*i +: 8]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m1_v = 1'b0; m1_out = '0;
        m2_s1v = 1'b0; m2_byte = '0; m2_sel = '0; m2_mode = '0;
        m2_v = 1'b0; m2_out = '0;
    endtask

    // Advance the model for the coming edge, take the edge, then compare.
    task automatic tick();
        logic adv;
        adv = en && !rst;
        if (adv) begin
            m2_out  = ref_beat(m2_mode, m2_sel, m2_byte);
            m2_v    = m2_s1v;
            m2_s1v  = in_valid;
            m2_byte = in_byte;
            m2_sel  = in_sel;
            m2_mode = mode;
            m1_out  = ref_beat(mode, in_sel, in_byte);
            m1_v    = in_valid;
            if (in_valid) acc2++;
        end
        @(posedge clk);
        #1;
        if (adv && ov2) seen2++;
        chk("l1_valid", 128'(ov1), 128'(m1_v));
        if (m1_v) chk("l1_out", out1, m1_out);
        chk("l2_valid", 128'(ov2), 128'(m2_v));
        if (m2_v) chk("l2_out", out2, m2_out);
    endtask

    task automatic drive_random();
        in_valid = 1'($urandom);
        mode     = 2'($urandom);
        in_byte  = L*8'($urandom);
        in_sel   = L*2'($urandom);
    endtask

    initial begin
        logic [L*32-1:0] held;
        logic            hv;

        build_tables();
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; mode = 2'd0; in_byte = '0; in_sel = '0;
        model_clear();
        #1;
        chk("reset_ov1", 128'(ov1), 128'd0);
        chk("reset_out1", out1, 128'd0);
        chk("reset_ov2", 128'(ov2), 128'd0);
        chk("reset_out2", out2, 128'd0);
        tick();
        tick();
        rst = 1'b0;
        en  = 1'b1;

        // Directed table values
        in_valid = 1'b1; mode = 2'd0; in_byte = {8'h01, 8'hFF, 8'h52, 8'h00}; in_sel = 8'h00;
        tick();
        chk("enc_k0", out1, 128'hF87C7C84_2C16163A_00000000_C66363A5);
        chk("enc_k0_v", 128'(ov1), 128'd1);
        mode = 2'd0; in_byte = 32'h0000_0001; in_sel = 8'b00_00_00_10;
        tick();
        chk("enc_k2", 128'(out1[31:0]), 128'h7C84F87C);
        mode = 2'd1; in_byte = 32'h0; in_sel = 8'b00_00_01_00;
        tick();
        chk("dec_k0", 128'(out1[31:0]), 128'h51F4A750);
        chk("dec_k1", 128'(out1[63:32]), 128'h5051F4A7);
        mode = 2'd2; in_byte = 32'h0000_0053; in_sel = 8'h00;
        tick();
        chk("enc_last", 128'(out1[31:0]), 128'hED000000);
        mode = 2'd3; in_byte = 32'h0; in_sel = 8'b00_00_00_11;
        tick();
        chk("dec_last", 128'(out1[31:0]), 128'h00000052);
        chk("l2_lag", 128'(out2[31:0]), 128'hED000000);
        in_valid = 1'b0;
        tick();
        chk("l2_dec_last", 128'(out2[31:0]), 128'h00000052);

        // LATENCY=2 back-to-back beats with a 3-cycle stall mid-stream
        acc2 = 0; seen2 = 0;
        for (int n = 0; n < 6; n++) begin
            drive_random();
            in_valid = 1'b1;
            tick();
            if (n == 2) begin
                held = out2; hv = ov2;
                en = 1'b0;
                repeat (3) begin
                    drive_random();
                    tick();
                    chk("stall_hold_out", out2, held);
                    chk("stall_hold_v", 128'(ov2), 128'(hv));
                end
                en = 1'b1;
            end
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("l2_beat_count", 128'(seen2), 128'(acc2));

        // Reset asserted mid-cycle with beats in flight
        drive_random(); in_valid = 1'b1; tick();
        drive_random(); in_valid = 1'b1; tick();
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        chk("midrst_ov1", 128'(ov1), 128'd0);
        chk("midrst_out1", out1, 128'd0);
        chk("midrst_ov2", 128'(ov2), 128'd0);
        chk("midrst_out2", out2, 128'd0);
        drive_random(); in_valid = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk("rel_ov2", 128'(ov2), 128'd0);

        // Random traffic with random stalls
        for (int n = 0; n < 300; n++) begin
            drive_random();
            en = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Sweep every byte x k x mode, lanes carrying different k each beat
        for (int m = 0; m < 4; m++) begin
            for (int b = 0; b < 256; b++) begin
                mode = 2'(m); in_valid = 1'b1;
                for (int i = 0; i < L; i++) begin
                    in_byte[8*i +: 8] = 8'(b);
                    in_sel[2*i +: 2]  = 2'((i + b) % 4);
                end
                do begin
                    en = ($urandom_range(0, 7) != 0);
                    tick();
                end while (!en);
            end
        end
        en = 1'b1; in_valid = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
